fwid_serial_reader: RTL

Parametrised firmware-ID store and readout engine. Holds `NUM_WORDS` ROM words of `WORD_W` bits each, fixed at elaboration. On request it streams one word, or all words in sequence, as an MSB-first bit-serial stream. Each word is also presented in parallel. It sits between the housekeeping/slow-control logic and the board-ID path, and replaces the single 64×1 bit-addressed ID ROM.

---
 rtl/fwid_pkg.sv | 46 ++++
 rtl/fwid_rom.sv | 38 +++
 rtl/fwid_serial_reader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fwid_pkg.sv
// fwid_pkg: shared types, constants and helpers for the firmware-ID readout.
//   fwid_state_e      - readout FSM state encoding (ST_CSUM only when
//                       FWID_CHECKSUM_EN is defined)
//   FWID_INIT_DEFAULT - default ROM contents, word 0 in the MSBs
//   fwid_xor_fold     - XOR of all ROM words, evaluated at elaboration
package fwid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_NEXT  = 3'd3
`ifdef FWID_CHECKSUM_EN
    , ST_CSUM = 3'd4
`endif
  } fwid_state_e;

  localparam int FWID_MAX_WORD_W = 64;
  localparam int FWID_MAX_WORDS  = 16;
  localparam int FWID_MAX_BITS   = FWID_MAX_WORD_W * FWID_MAX_WORDS;

  localparam logic [127:0] FWID_INIT_DEFAULT =
    {32'h1234DEAD, 32'hBEEF5678, 32'hCAFEF00D, 32'h00000001};

  // The packed image is zero-extended to the maximum size so one function
  // serves every parameterisation; XOR is order-independent, so the words
  // are folded starting from the LSB end.
  function automatic logic [FWID_MAX_WORD_W-1:0] fwid_xor_fold(
    input logic [FWID_MAX_BITS-1:0] init,
    input int                       word_w,
    input int                       num_words
  );
    logic [FWID_MAX_WORD_W-1:0] acc;
    logic [FWID_MAX_WORD_W-1:0] mask;
    acc  = '0;
    mask = (word_w >= FWID_MAX_WORD_W) ? '1 :
           ((FWID_MAX_WORD_W'(1) << word_w) - FWID_MAX_WORD_W'(1));
    for (int i = 0; i < FWID_MAX_WORDS; i++) begin
      if (i < num_words) begin
        acc = acc ^ (FWID_MAX_WORD_W'(init >> (i * word_w)) & mask);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/fwid_rom.sv
// fwid_rom: elaboration-time ID ROM with a one-cycle registered read.
// Ports:
//   clk  in  1       clock
//   addr in  ADDR_W  word index
//   dout out WORD_W  word at addr (zero when addr is out of range)
//   oob  out 1       addr was >= NUM_WORDS on the last read
module fwid_rom
  import fwid_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter logic [NUM_WORDS*WORD_W-1:0] INIT = '0
)(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] dout,
  output logic              oob
);

  logic [WORD_W-1:0] mem [NUM_WORDS];

  // Word 0 sits in the MSBs of the packed image.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
    assign mem[g] = INIT[(NUM_WORDS-1-g)*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk) begin
    if (32'(addr) < NUM_WORDS) begin
      dout <= mem[addr];
      oob  <= 1'b0;
    end else begin
      dout <= '0;
      oob  <= 1'b1;
    end
  end

endmodule

// File: rtl/fwid_serial_reader.sv
// fwid_serial_reader: firmware-ID store with MSB-first bit-serial readout of
// one word or of all words in sequence; each word is also shown in parallel.
// Optional feature macro: FWID_CHECKSUM_EN appends the XOR of all ROM words
// to an all-words dump.
// Ports:
//   clk        in  1       clock
//   rst        in  1       synchronous active-high reset
//   req_valid  in  1       read request
//   req_ready  out 1       high only while idle
//   req_all    in  1       1 = dump all words, 0 = single word
//   req_addr   in  ADDR_W  word index for a single read
//   bit_out    out 1       serial data, MSB first
//   bit_valid  out 1       bit_out valid
//   bit_last   out 1       final bit of the transfer
//   word_out   out WORD_W  word currently being shifted
//   word_start out 1       pulse with the first bit of each word
//   addr_err   out 1       sticky out-of-range single-read flag
module fwid_serial_reader
  import fwid_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter logic [NUM_WORDS*WORD_W-1:0] INIT = FWID_INIT_DEFAULT
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_all,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_last,
  output logic [WORD_W-1:0] word_out,
  output logic              word_start,
  output logic              addr_err
);

  localparam int                CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

`ifdef FWID_CHECKSUM_EN
  localparam logic [WORD_W-1:0] CSUM_WORD =
    WORD_W'(fwid_xor_fold(FWID_MAX_BITS'(INIT), WORD_W, NUM_WORDS));
`endif

  fwid_state_e       state_q, state_d;
  logic              all_q, all_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_d;
  logic              bit_d, valid_d, last_d, start_d, ready_d, err_d;
  logic              load_en;
  logic [WORD_W-1:0] load_word;
  logic [WORD_W-1:0] rom_dout;
  logic              rom_oob;
  logic              more_words;
  logic              final_word;

`ifdef FWID_CHECKSUM_EN
  logic in_csum_q, in_csum_d;
  logic csum_wait_q, csum_wait_d;
`endif

  // The ROM is addressed with the next-address value so its registered
  // output is already valid during the LOAD cycle.
  fwid_rom #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W),
    .INIT      (INIT)
  ) u_rom (
    .clk  (clk),
    .addr (addr_d),
    .dout (rom_dout),
    .oob  (rom_oob)
  );

  assign more_words = all_q && (addr_q != LAST_ADDR);
`ifdef FWID_CHECKSUM_EN
  assign final_word = all_q ? in_csum_q : 1'b1;
`else
  assign final_word = !more_words;
`endif

  always_comb begin
    state_d   = state_q;
    all_d     = all_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_d    = word_out;
    err_d     = addr_err;
    bit_d     = 1'b0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    start_d   = 1'b0;
    load_en   = 1'b0;
    load_word = rom_dout;
`ifdef FWID_CHECKSUM_EN
    in_csum_d   = in_csum_q;
    csum_wait_d = csum_wait_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          all_d   = req_all;
          addr_d  = req_all ? '0 : req_addr;
          state_d = ST_LOAD;
`ifdef FWID_CHECKSUM_EN
          in_csum_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        err_d   = addr_err | rom_oob;
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          // shreg already holds the next bit in its MSB
          bit_d   = shreg_q[WORD_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          valid_d = 1'b1;
          last_d  = (cnt_q == CNT_LAST - CNT_W'(1)) && final_word;
        end else if (more_words) begin
          state_d = ST_NEXT;
`ifdef FWID_CHECKSUM_EN
        end else if (all_q && !in_csum_q) begin
          state_d = ST_CSUM;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NEXT: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_LOAD;
      end
`ifdef FWID_CHECKSUM_EN
      // First cycle mirrors NEXT, second mirrors LOAD, so the checksum word
      // sees the same two-cycle bubble as a ROM word.
      ST_CSUM: begin
        if (!csum_wait_q) begin
          csum_wait_d = 1'b1;
        end else begin
          csum_wait_d = 1'b0;
          in_csum_d   = 1'b1;
          load_en     = 1'b1;
          load_word   = CSUM_WORD;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // First bit is presented directly from the loaded word; the shift
    // register keeps the remainder.
    if (load_en) begin
      shreg_d = load_word << 1;
      word_d  = load_word;
      bit_d   = load_word[WORD_W-1];
      valid_d = 1'b1;
      start_d = 1'b1;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      all_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_out   <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      bit_last   <= 1'b0;
      word_start <= 1'b0;
      req_ready  <= 1'b1;
      addr_err   <= 1'b0;
`ifdef FWID_CHECKSUM_EN
      in_csum_q   <= 1'b0;
      csum_wait_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      all_q      <= all_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_out   <= word_d;
      bit_out    <= bit_d;
      bit_valid  <= valid_d;
      bit_last   <= last_d;
      word_start <= start_d;
      req_ready  <= ready_d;
      addr_err   <= err_d;
`ifdef FWID_CHECKSUM_EN
      in_csum_q   <= in_csum_d;
      csum_wait_q <= csum_wait_d;
`endif
    end
    shreg_q <= shreg_d;
  end

endmodule
